// File: rtl/weapon_angle_controller.sv
// Aim/fire controller: rotates a 4-bit aim angle, sequences a shot through
// FIRING and COOLDOWN, tracks a wide-beam power-up and counts enemy hits.
module weapon_angle_controller #(
  parameter int unsigned FIRE_CYCLES     = 8,
  parameter int unsigned COOLDOWN_CYCLES = 16,
  parameter int unsigned WIDE_CYCLES     = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rot_cw,
  input  logic        rot_ccw,
  input  logic        fire,
  input  logic        powerup,
  input  logic        enemy_valid,
  input  logic [3:0]  enemy_angle,
  input  logic [15:0] angles_hit,
  output logic [3:0]  angle,
  output logic        mode,
  output logic        beam_on,
  output logic        ready,
  output logic        hit,
  output logic [7:0]  hit_count
);

  localparam int unsigned PMAX = (FIRE_CYCLES > COOLDOWN_CYCLES) ? FIRE_CYCLES : COOLDOWN_CYCLES;
  localparam int PW = (PMAX > 1) ? $clog2(PMAX) : 1;
  localparam int WW = (WIDE_CYCLES > 1) ? $clog2(WIDE_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, FIRING, COOLDOWN} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [WW-1:0] wide_q, wide_d;
  logic [3:0]    angle_q, angle_d;
  logic          mode_q, mode_d;
  logic          hit_q, hit_d;
  logic [7:0]    hit_count_q, hit_count_d;
  logic          hit_det;
  logic          wide_active;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      wide_q      <= '0;
      angle_q     <= '0;
      mode_q      <= 1'b0;
      hit_q       <= 1'b0;
      hit_count_q <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      wide_q      <= wide_d;
      angle_q     <= angle_d;
      mode_q      <= mode_d;
      hit_q       <= hit_d;
      hit_count_q <= hit_count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    angle_d     = angle_q;
    mode_d      = mode_q;
    hit_count_d = hit_count_q;

    // The mask is a live function of angle/mode, so it is sampled, never stored.
    hit_det     = (state_q == FIRING) && enemy_valid && angles_hit[enemy_angle];
    wide_active = powerup || (wide_q != '0);

    if (powerup)
      wide_d = WW'(WIDE_CYCLES - 1);
    else if (wide_q != '0)
      wide_d = wide_q - WW'(1);
    else
      wide_d = wide_q;

    unique case (state_q)
      IDLE: begin
        if (fire) begin
          state_d = FIRING;
          phase_d = PW'(FIRE_CYCLES - 1);
        end
      end
      FIRING: begin
        if ((phase_q == '0) || hit_det) begin
          state_d = COOLDOWN;
          phase_d = PW'(COOLDOWN_CYCLES - 1);
        end else begin
          phase_d = phase_q - PW'(1);
        end
      end
      COOLDOWN: begin
        if (phase_q == '0)
          state_d = IDLE;
        else
          phase_d = phase_q - PW'(1);
      end
      default: state_d = IDLE;
    endcase

    if (state_q != FIRING) begin
      unique case ({rot_cw, rot_ccw})
        2'b10:   angle_d = angle_q + 4'd1;
        2'b01:   angle_d = angle_q - 4'd1;
        default: angle_d = angle_q;
      endcase
    end

    // Width is frozen only across edges that keep the beam on.
    if (!((state_q == FIRING) && (state_d == FIRING)))
      mode_d = wide_active;

    hit_d = hit_det;
    if (hit_det && (hit_count_q != 8'hFF))
      hit_count_d = hit_count_q + 8'd1;
  end

  assign angle     = angle_q;
  assign mode      = mode_q;
  assign beam_on   = (state_q == FIRING);
  assign ready     = (state_q == IDLE);
  assign hit       = hit_q;
  assign hit_count = hit_count_q;

endmodule

// File: doc/weapon_angle_controller.md
WEAPON_ANGLE_CONTROLLER -- requirements
Module: weapon_angle_controller

Interface
REQ-001 The block SHALL have parameter FIRE_CYCLES, default 8, meaning beam-active duration in clocks (>=1).
REQ-002 The block SHALL have parameter COOLDOWN_CYCLES, default 16, meaning lockout after a shot ends (>=1).
REQ-003 The block SHALL have parameter WIDE_CYCLES, default 1024, meaning wide-mode power-up duration (>=1).
REQ-004 clk  in  1  sole clock; all state SHALL change on its rising edge.
REQ-005 rst  in  1  reset, asynchronous and active-high.
REQ-006 rot_cw  in  1  one-cycle request to increment the aim angle.
REQ-007 rot_ccw  in  1  one-cycle request to decrement the aim angle.
REQ-008 fire  in  1  level request to fire.
REQ-009 powerup  in  1  one-cycle pulse that starts or restarts wide mode.
REQ-010 enemy_valid  in  1  enemy_angle is meaningful this cycle.
REQ-011 enemy_angle  in  4  angular sector occupied by the enemy.
REQ-012 angles_hit  in  16  one-hot-run hit mask returned by the hit-mask generator for the current angle/mode outputs.
REQ-013 angle  out  4  registered aim angle fed to the hit-mask generator.
REQ-014 mode  out  1  registered width select fed to the generator (1 = 5-sector, 0 = 3-sector).
REQ-015 beam_on  out  1  high while in FIRING.
REQ-016 ready  out  1  high while in IDLE.
REQ-017 hit  out  1  one-cycle registered hit pulse.
REQ-018 hit_count  out  8  saturating count of hits.

Function
REQ-019 The FSM SHALL have states IDLE, FIRING and COOLDOWN.
REQ-020 IDLE->FIRING SHALL occur on the edge where fire=1 in IDLE; the phase counter SHALL load FIRE_CYCLES-1.
REQ-021 FIRING->COOLDOWN SHALL occur when the phase counter reaches 0 or when a hit is detected, whichever is first; the counter SHALL load COOLDOWN_CYCLES-1.
REQ-022 COOLDOWN->IDLE SHALL occur when the phase counter reaches 0; fire held continuously SHALL re-fire only after at least one cycle in IDLE.
REQ-023 The beam_on high time SHALL be exactly FIRE_CYCLES clocks when no hit occurs.
REQ-024 In IDLE and COOLDOWN, rot_cw alone SHALL give angle+1 mod 16 and rot_ccw alone SHALL give angle-1 mod 16 on the next edge; 15+1 SHALL give 0 and 0-1 SHALL give 15.
REQ-025 If rot_cw and rot_ccw are both high, angle SHALL NOT change.
REQ-026 In FIRING, angle SHALL be frozen and rotation requests SHALL be discarded, not queued.
REQ-027 The wide timer SHALL load WIDE_CYCLES-1 on powerup, in any state, and decrement to 0 each cycle; wide_active SHALL be timer>0 or a load occurring this cycle.
REQ-028 mode SHALL be updated from wide_active only in IDLE and COOLDOWN and SHALL be held constant throughout FIRING; expiry during FIRING SHALL take effect at entry to COOLDOWN.
REQ-029 A hit SHALL be detected in FIRING when enemy_valid=1 and angles_hit[enemy_angle]=1; hit SHALL pulse on the following edge.
REQ-030 There SHALL be at most one hit per shot.
REQ-031 hit_count SHALL increment by 1 per hit pulse and SHALL saturate at 255.
REQ-032 angles_hit SHALL be treated as combinational from angle/mode; the block SHALL NOT register it.

Reset
REQ-033 When rst is asserted, the block SHALL asynchronously force: state=IDLE, angle=0, mode=0, beam_on=0, ready=1, hit=0, hit_count=0, and phase and wide counters to 0.
REQ-034 Reset asserted mid-FIRING SHALL abort the shot with no hit pulse.
REQ-035 The first edge after rst deasserts SHALL evaluate inputs normally.

Verification
REQ-036 Reset, then 17 rot_cw pulses -> angle=1; then 2 rot_ccw pulses -> angle=15; then rot_cw with rot_ccw together -> angle stays 15.
REQ-037 fire for 1 cycle with no enemy -> beam_on high exactly 8 clocks, then ready=0 for 16 clocks, then ready=1; rot_cw during beam -> angle unchanged.
REQ-038 angle=4, mode=0, enemy_angle=6 held valid during the shot -> no hit; after powerup, next shot -> hit pulse of 1 cycle, beam_on drops the cycle after detection, hit_count=1.
REQ-039 angle=0, mode=1, enemy_angle=14 -> hit, confirming wrap-around of the mask.
REQ-040 WIDE_CYCLES=4: powerup, fire immediately, timer expires mid-shot -> mode stays 1 until COOLDOWN entry, then 0; powerup again at expiry -> mode stays 1.
REQ-041 Force 256 hits -> hit_count=255; assert rst mid-FIRING -> all outputs at reset values within the same cycle.
